// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester round-robin arbiter time-sharing one 32-bit ALU
//
// Purpose: accepts one operation at a time from either of two requesters, runs it
// through a single shared combinational ALU and returns a registered result.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid/req_ready         per-requester request handshake (bit i = requester i)
//   req_a, req_b, req_op        per-requester operands and ALUop (slice i = requester i)
//   resp_valid/resp_ready       per-requester response handshake
//   resp_result, resp_flags     registered Result and {Overflow, CarryOut, Zero}
//   resp_err                    registered illegal-ALUop indication
//   busy                        high whenever an operation is in flight

module alu_share_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [2:0]            op_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  overflow_o,
  output logic                  carry_o,
  output logic                  zero_o
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;
  logic                ovf_add;
  logic                ovf_sub;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_WIDTH{1'b0}}, 1'b1};

  assign ovf_add = (a_i[DATA_WIDTH-1] == b_i[DATA_WIDTH-1]) &&
                   (sum[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
  assign ovf_sub = (a_i[DATA_WIDTH-1] != b_i[DATA_WIDTH-1]) &&
                   (diff[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    carry_o    = 1'b0;
    case (op_i)
      3'b000: result_o = a_i & b_i;
      3'b001: result_o = a_i | b_i;
      3'b010: begin
        result_o   = sum[DATA_WIDTH-1:0];
        overflow_o = ovf_add;
        carry_o    = sum[DATA_WIDTH];
      end
      3'b110: begin
        result_o   = diff[DATA_WIDTH-1:0];
        overflow_o = ovf_sub;
        // Borrow is the inverse of the carry out of A + ~B + 1.
        carry_o    = ~diff[DATA_WIDTH];
      end
      3'b111: begin
        // Signed less-than: sign of the difference corrected for overflow.
        result_o   = {{(DATA_WIDTH-1){1'b0}}, diff[DATA_WIDTH-1] ^ ovf_sub};
        overflow_o = ovf_sub;
        carry_o    = ~diff[DATA_WIDTH];
      end
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

module alu_share_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  input  logic [5:0]              req_op,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_result,
  output logic [FLAG_W-1:0]       resp_flags,
  output logic                    resp_err,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic                  g_q, g_d;
  logic                  prio_q, prio_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [FLAG_W-1:0]     flags_q, flags_d;
  logic                  err_q, err_d;

  logic                  grant;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_ovf;
  logic                  alu_carry;
  logic                  alu_zero;

  // The ALU only ever sees the latched operands, so requester inputs may
  // change freely once accepted.
  alu_share_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .op_i       (op_q),
    .result_o   (alu_result),
    .overflow_o (alu_ovf),
    .carry_o    (alu_carry),
    .zero_o     (alu_zero)
  );

  assign illegal = (op_q == 3'b011) || (op_q == 3'b100) || (op_q == 3'b101);

  // Tie goes to the priority pointer; otherwise the single valid requester wins.
  assign grant = (&req_valid) ? prio_q : req_valid[1];

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    prio_d     = prio_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    flags_d    = flags_q;
    err_d      = err_q;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          g_d     = grant;
          a_d     = grant ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
          b_d     = grant ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
          op_d    = grant ? req_op[5:3] : req_op[2:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (illegal) begin
          result_d = '0;
          flags_d  = '0;
          err_d    = 1'b1;
        end else begin
          result_d = alu_result;
          flags_d  = {alu_ovf, alu_carry, alu_zero};
          err_d    = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid[g_q] = 1'b1;
        if (resp_ready[g_q]) begin
          prio_d  = ~g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      g_q      <= 1'b0;
      prio_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      prio_q   <= prio_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb

module tb_alu_share_arb;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [5:0]      req_op;
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [DW-1:0]   resp_result;
  logic [2:0]      resp_flags;
  logic            resp_err;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.DATA_WIDTH(DW), .FLAG_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] mask(input int p);
    return (p != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    if (p == 0) begin
      req_a[31:0] = a;
      req_b[31:0] = b;
      req_op[2:0] = op;
    end else begin
      req_a[63:32] = a;
      req_b[63:32] = b;
      req_op[5:3]  = op;
    end
    req_valid[p] = 1'b1;
  endtask

  // Returns at the falling edge of the accept cycle.
  task automatic wait_grant(input int p, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready[p] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(req_ready), 64'(mask(p)));
  endtask

  // Called at the falling edge of the accept cycle; finishes at the first IDLE cycle after.
  task automatic collect(input int p, input logic [31:0] er, input logic [2:0] ef,
                         input logic ee, input string tag);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    @(negedge clk);
    check({tag, "_exec"}, 64'({busy, resp_valid}), 64'(3'b100));
    @(negedge clk);
    check({tag, "_rvalid"}, 64'(resp_valid), 64'(mask(p)));
    check({tag, "_result"}, 64'(resp_result), 64'(er));
    check({tag, "_flags"}, 64'(resp_flags), 64'(ef));
    check({tag, "_err"}, 64'(resp_err), 64'(ee));
    resp_ready[p] = 1'b1;
    @(posedge clk); #1;
    resp_ready[p] = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, 64'({busy, resp_valid}), 64'(3'b000));
  endtask

  task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] er, input logic [2:0] ef,
                        input logic ee, input string tag);
    set_req(p, a, b, op);
    wait_grant(p, {tag, "_grant"});
    collect(p, er, ef, ee, tag);
  endtask

  initial begin
    int ng;
    int nr;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rexp;
    logic [2:0]  rop;

    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", 64'({req_ready, resp_valid, busy}), 64'(5'b00000));
    check("reset_resp", 64'({resp_result, resp_flags, resp_err}), 64'(0));

    // Signed overflow on ADD; prio moves to 1 afterwards.
    @(posedge clk); #1;
    run_op(0, 32'h7FFF_FFFF, 32'h1, 3'b010, 32'h8000_0000, 3'b100, 1'b0, "add");

    // Illegal op from port 1; prio moves back to 0.
    @(posedge clk); #1;
    run_op(1, 32'h1234_5678, 32'hFFFF_0000, 3'b101, 32'h0, 3'b000, 1'b1, "illegal");

    // Tie: both valid continuously, grants must alternate 0,1,0,1.
    @(posedge clk); #1;
    set_req(0, 32'd5, 32'd5, 3'b110);
    set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b111);
    ng = 0;
    nr = 0;
    for (int cyc = 0; cyc < 80 && nr < 4; cyc++) begin
      @(negedge clk);
      if (|req_ready) begin
        if (ng < 4) check("tie_grant", 64'(req_ready), 64'(mask(ng % 2)));
        ng++;
      end
      if (|resp_valid) begin
        if (resp_valid[0])
          check("tie_sub", 64'({resp_result, resp_flags, resp_err}), 64'({32'd0, 3'b001, 1'b0}));
        else
          check("tie_slt", 64'({resp_result, resp_flags, resp_err}), 64'({32'd1, 3'b000, 1'b0}));
        resp_ready = resp_valid;
        nr++;
      end else begin
        resp_ready = 2'b00;
      end
    end
    req_valid = 2'b00;
    check("tie_count", 64'({ng[7:0], nr[7:0]}), 64'({8'd4, 8'd4}));
    @(posedge clk); #1;
    resp_ready = 2'b00;

    // Back-pressure on port 1 while port 0 waits.
    @(posedge clk); #1;
    set_req(1, 32'd3, 32'd4, 3'b010);
    wait_grant(1, "bp_grant");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(0, 32'd10, 32'd20, 3'b010);
    @(negedge clk);
    check("bp_exec_ready", 64'(req_ready), 64'(2'b00));
    @(negedge clk);
    check("bp_resp", 64'({resp_valid, resp_result, resp_flags, resp_err}),
          64'({2'b10, 32'd7, 3'b000, 1'b0}));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", 64'({req_ready, resp_valid, resp_result, resp_flags, resp_err}),
            64'({2'b00, 2'b10, 32'd7, 3'b000, 1'b0}));
    end
    resp_ready = 2'b10;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    @(negedge clk);
    check("bp_next_grant", 64'(req_ready), 64'(2'b01));
    collect(0, 32'd30, 3'b000, 1'b0, "bp_p0");

    // prio is now 1: a tie grants port 1; reset in its RESP must restore prio 0.
    @(posedge clk); #1;
    set_req(0, 32'd1, 32'd1, 3'b010);
    set_req(1, 32'hF0F0_0000, 32'h0000_0F0F, 3'b001);
    wait_grant(1, "rst_tie_grant");
    @(posedge clk); #1;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_rvalid", 64'(resp_valid), 64'(2'b10));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_ctrl", 64'({busy, resp_valid, req_ready}), 64'(5'b00001));
    check("rst_after_result", 64'(resp_result), 64'(0));
    collect(0, 32'd2, 3'b000, 1'b0, "rst_p0");
    req_valid = 2'b00;

    // AND/OR sweep with random operands, alternating ports.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ra   = $urandom;
      rb   = $urandom;
      rop  = ((i / 2) % 2 != 0) ? 3'b001 : 3'b000;
      rexp = (rop == 3'b001) ? (ra | rb) : (ra & rb);
      run_op(i % 2, ra, rb, rop, rexp, {2'b00, rexp == 32'd0}, 1'b0, "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
